// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-style serial slave.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEIVE = 3'd1,
    DONE    = 3'd2,
    WAIT_TX = 3'd3,
    SEND    = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave.sv
// Serial slave: assembles a command frame from MOSI and, for read-data,
// returns one byte on MISO. dbg_state exposes the FSM state.
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_W = spi_pkg::FRAME_W,
  parameter int DATA_W  = spi_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               MOSI,
  input  logic               SS_n,
  input  logic               tx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  output logic               MISO,
  output logic               rx_valid,
  output logic [FRAME_W-1:0] rx_data,
  output state_e             dbg_state
);

  localparam int MAX_W = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  // Handshakes: rx_valid is a one-cycle pulse with no backpressure; tx_valid
  // is consumed on the first WAIT_TX cycle it is high (no ready is returned).
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic               miso_q, miso_d;
  logic               rx_valid_q, rx_valid_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      IDLE: begin
        if (!SS_n) begin
          shift_d = {{(FRAME_W-2){1'b0}}, MOSI};
          cnt_d   = CNT_W'(1);
          state_d = RECEIVE;
        end
      end

      RECEIVE: begin
        if (SS_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(FRAME_W - 1)) begin
          rx_data_d  = {shift_q, MOSI};
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          // shift_q holds frame bits [9:1], so its top two bits are the command
          state_d    = (shift_q[FRAME_W-2 -: 2] == CMD_RD_DATA) ? WAIT_TX : DONE;
        end else begin
          shift_d = {shift_q[FRAME_W-3:0], MOSI};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (SS_n) state_d = IDLE;
      end

      WAIT_TX: begin
        if (SS_n) begin
          state_d = IDLE;
        end else if (tx_valid) begin
          miso_d     = tx_data[DATA_W-1];
          tx_shift_d = {tx_data[DATA_W-2:0], 1'b0};
          cnt_d      = CNT_W'(1);
          state_d    = SEND;
        end
      end

      SEND: begin
        if (SS_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: random frames checked against a bit-list model of the
// serial protocol; inputs change and outputs are sampled on falling edges.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       MOSI;
  logic       SS_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       MISO;
  logic       rx_valid;
  logic [9:0] rx_data;
  state_e     dbg_state;

  int         checks;
  int         errors;
  logic [9:0] last_rx;

  spi_slave dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .MISO      (MISO),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", rx_data); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    last_rx = 10'h000;
    reset_n = 1'b0;
  endtask

  // Sends nbits MOSI bits in one SS_n window (first 10 from frame, the rest
  // random), then raises SS_n. Model: a frame exists iff >= 10 bits were sent,
  // and it is the first 10 bits read MSB first.
  task automatic send_frame(input logic [9:0] frame, input int nbits, input string name);
    bit q[$];
    int acc;
    bit complete;
    logic [9:0] exp_d;
    for (int i = 0; i < nbits; i++)
      q.push_back((i < 10) ? frame[9-i] : 1'($urandom_range(0, 1)));
    acc = 0;
    for (int i = 0; i < 10 && i < q.size(); i++) acc = acc * 2 + int'(q[i]);
    complete = (nbits >= 10);
    for (int i = 0; i <= nbits; i++) begin
      exp_d = (complete && i >= 10) ? 10'(acc) : last_rx;
      checks++; if (rx_valid !== (i == 10)) begin errors++; $display("FAIL %s_rx_valid bit%0d: got %b expected %b", name, i, rx_valid, (i == 10)); end
      checks++; if (rx_data !== exp_d) begin errors++; $display("FAIL %s_rx_data bit%0d: got %h expected %h", name, i, rx_data, exp_d); end
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL %s_miso bit%0d: got %b expected 0", name, i, MISO); end
      if (i < nbits) begin
        SS_n = 1'b0; MOSI = q[i];
        @(negedge clk);
      end
    end
    if (complete) last_rx = 10'(acc);
    SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s_end_rx_valid: got %b expected 0", name, rx_valid); end
    checks++; if (rx_data !== last_rx) begin errors++; $display("FAIL %s_end_rx_data: got %h expected %h", name, rx_data, last_rx); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL %s_end_state: got %0d expected IDLE", name, dbg_state); end
  endtask

  // Read-data: cmd 11 frame, tx_valid raised after 'delay' WAIT_TX cycles,
  // expected MISO = tx byte MSB first. reset_at >= 0 resets during that bit.
  task automatic test_read(input logic [7:0] tx, input int delay, input int reset_at, input string name);
    logic [9:0] frame;
    frame = {2'b11, 8'($urandom_range(0, 255))};
    tx_valid = (delay == 0); tx_data = tx;
    for (int i = 0; i < 10; i++) begin
      SS_n = 1'b0; MOSI = frame[9-i];
      @(negedge clk);
      checks++; if (rx_valid !== (i == 9)) begin errors++; $display("FAIL %s_rx_valid bit%0d: got %b expected %b", name, i, rx_valid, (i == 9)); end
    end
    checks++; if (rx_data !== frame) begin errors++; $display("FAIL %s_rx_data: got %h expected %h", name, rx_data, frame); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL %s_miso_pre: got %b expected 0", name, MISO); end
    last_rx = frame;
    MOSI = 1'($urandom_range(0, 1));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL %s_miso_wait%0d: got %b expected 0", name, k, MISO); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s_rx_valid_wait%0d: got %b expected 0", name, k, rx_valid); end
    end
    tx_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = 8'($urandom_range(0, 255));
      MOSI = 1'($urandom_range(0, 1));
      checks++; if (MISO !== tx[7-j]) begin errors++; $display("FAIL %s_miso_bit%0d: got %b expected %b", name, 7 - j, MISO, tx[7-j]); end
      if (j == reset_at) begin
        reset_n = 1'b1; SS_n = 1'b1;
        @(negedge clk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL %s_rst_miso: got %b expected 0", name, MISO); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL %s_rst_state: got %0d expected IDLE", name, dbg_state); end
        checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL %s_rst_rx_data: got %h expected 000", name, rx_data); end
        last_rx = 10'h000;
        reset_n = 1'b0;
        return;
      end
    end
    @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL %s_miso_after: got %b expected 0", name, MISO); end
    checks++; if (dbg_state !== DONE) begin errors++; $display("FAIL %s_state_after: got %0d expected DONE", name, dbg_state); end
    SS_n = 1'b1;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL %s_state_idle: got %0d expected IDLE", name, dbg_state); end
    checks++; if (rx_data !== last_rx) begin errors++; $display("FAIL %s_rx_hold: got %h expected %h", name, rx_data, last_rx); end
  endtask

  task automatic test_writes();
    send_frame(10'b00_0000_0001, 10, "wr_addr");
    send_frame(10'b01_0000_0011, 10, "wr_data");
    send_frame(10'b10_0000_0011, 10, "rd_addr");
  endtask

  task automatic test_abort();
    send_frame(10'($urandom_range(0, 1023)), 5, "abort");
    send_frame(10'h0A5, 10, "after_abort");
  endtask

  task automatic test_extra_bits();
    send_frame(10'($urandom_range(0, 1023)), 13, "extra_bits");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      send_frame(10'($urandom_range(0, 1023)), $urandom_range(2, 14), "b2b");
  endtask

  task automatic test_read_data();
    test_read(8'hCC, 0, -1, "rd_cc");
    for (int n = 0; n < 3; n++)
      test_read(8'($urandom_range(0, 255)), $urandom_range(0, 4), -1, "rd_rand");
  endtask

  task automatic test_reset_mid_send();
    test_read(8'($urandom_range(0, 255)), 1, 3, "rst_send");
    send_frame(10'($urandom_range(0, 1023)), 10, "post_rst");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_writes();
    test_read_data();
    test_abort();
    test_extra_bits();
    test_back_to_back();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
